rpc_mc_engine: RTL and testbench

RPC_MC_ENGINE -- requirements
Module: rpc_mc_engine

---
 rtl/rpc_mc_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_rpc_mc_engine.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpc_mc_engine.sv
// RPC multi-channel engine: connection table setup, per-channel TX FIFOs with
// round-robin egress, RX delivery by connection lookup, saturating drop counter.

module rpc_mc_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    assign rdata = mem[rp];
    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
endmodule

module rpc_mc_engine #(
    parameter int NIC_ID     = 0,
    parameter int N_CH       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int RPC_W      = 256,
    parameter int CID_W      = 4,
    localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   conn_setup_en_in,
    input  logic [2:0]             conn_setup_cmd_in,
    input  logic [63:0]            conn_setup_data_in,
    output logic                   conn_setup_done_out,
    input  logic [N_CH-1:0]        rpc_valid_in,
    output logic [N_CH-1:0]        rpc_ready_out,
    input  logic [N_CH*CID_W-1:0]  rpc_conn_id_in,
    input  logic [N_CH*RPC_W-1:0]  rpc_data_in,
    output logic                   network_tx_valid_out,
    input  logic                   network_tx_ready_in,
    output logic [47:0]            network_tx_addr_out,
    output logic [63:0]            network_tx_qp_out,
    output logic [CW-1:0]          network_tx_ch_out,
    output logic [RPC_W-1:0]       network_tx_payload_out,
    input  logic                   network_rx_valid_in,
    input  logic [CW-1:0]          network_rx_ch_in,
    input  logic [CID_W-1:0]       network_rx_conn_id_in,
    input  logic [RPC_W-1:0]       network_rx_payload_in,
    output logic [N_CH-1:0]        rpc_valid_out,
    output logic [CID_W-1:0]       rpc_conn_id_out,
    output logic [RPC_W-1:0]       rpc_data_out,
    output logic [15:0]            drop_cnt_out,
    output logic                   error
);
    localparam int NCONN = 1 << CID_W;
    localparam int FW    = CID_W + RPC_W;

    // ---------------- connection setup / table ----------------
    logic [4:0]       sv;
    logic [CID_W-1:0] cid_r;
    logic             open_r;
    logic [31:0]      ip_r;
    logic [15:0]      port_r;
    logic [63:0]      qp_r;
    logic             fields_ok, commit;

    logic [NCONN-1:0] tbl_open;
    logic [47:0]      tbl_addr [NCONN];
    logic [63:0]      tbl_qp   [NCONN];

    assign fields_ok = open_r ? (&sv) : (sv[0] & sv[1]);
    assign commit    = conn_setup_en_in && (conn_setup_cmd_in == 3'd5) && fields_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            sv                  <= '0;
            cid_r               <= '0;
            open_r              <= 1'b0;
            ip_r                <= '0;
            port_r              <= '0;
            qp_r                <= '0;
            tbl_open            <= '0;
            error               <= 1'b0;
            conn_setup_done_out <= 1'b0;
        end else begin
            conn_setup_done_out <= commit;
            if (conn_setup_en_in) begin
                case (conn_setup_cmd_in)
                    3'd0: begin cid_r  <= conn_setup_data_in[CID_W-1:0]; sv[0] <= 1'b1; end
                    3'd1: begin open_r <= conn_setup_data_in[0];         sv[1] <= 1'b1; end
                    3'd2: begin ip_r   <= conn_setup_data_in[31:0];      sv[2] <= 1'b1; end
                    3'd3: begin port_r <= conn_setup_data_in[15:0];      sv[3] <= 1'b1; end
                    3'd4: begin qp_r   <= conn_setup_data_in;            sv[4] <= 1'b1; end
                    3'd5: begin
                        if (fields_ok) begin
                            tbl_open[cid_r] <= open_r;
                            sv              <= '0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    default: error <= 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            tbl_addr[cid_r] <= {ip_r, port_r};
            tbl_qp[cid_r]   <= qp_r;
        end
    end

    // ---------------- per-channel TX FIFOs ----------------
    logic [N_CH-1:0]         fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [N_CH-1:0][FW-1:0] fifo_rdata;

    assign rpc_ready_out = ~fifo_full & {N_CH{~reset}};

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign fifo_push[c] = rpc_valid_in[c] & rpc_ready_out[c];
        rpc_mc_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (fifo_push[c]),
            .wdata ({rpc_conn_id_in[c*CID_W +: CID_W], rpc_data_in[c*RPC_W +: RPC_W]}),
            .pop   (fifo_pop[c]),
            .rdata (fifo_rdata[c]),
            .empty (fifo_empty[c]),
            .full  (fifo_full[c])
        );
    end

    // ---------------- round-robin arbiter + TX output register ----------------
    logic [CW-1:0]    rr_p, gnt;
    logic             gnt_vld, pop_en, pop_fire, head_hit;
    logic [FW-1:0]    head;
    logic [CID_W-1:0] head_cid;
    logic             tx_drop;

    // Scan from the highest offset down so the nearest channel at/after rr_p wins.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = (int'(rr_p) + i) % N_CH;
            if (!fifo_empty[idx]) begin
                gnt_vld = 1'b1;
                gnt     = CW'(idx);
            end
        end
    end

    assign pop_en   = !network_tx_valid_out || network_tx_ready_in;
    assign pop_fire = pop_en && gnt_vld;
    assign head     = fifo_rdata[gnt];
    assign head_cid = head[FW-1 -: CID_W];
    assign head_hit = tbl_open[head_cid];
    assign tx_drop  = pop_fire && !head_hit;

    for (genvar c = 0; c < N_CH; c++) begin : g_pop
        assign fifo_pop[c] = pop_fire && (gnt == CW'(c));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_p                   <= '0;
            network_tx_valid_out   <= 1'b0;
            network_tx_addr_out    <= '0;
            network_tx_qp_out      <= '0;
            network_tx_ch_out      <= '0;
            network_tx_payload_out <= '0;
        end else if (pop_en) begin
            network_tx_valid_out <= pop_fire && head_hit;
            if (pop_fire) begin
                rr_p <= (gnt == CW'(N_CH - 1)) ? '0 : gnt + CW'(1);
                if (head_hit) begin
                    network_tx_addr_out    <= tbl_addr[head_cid];
                    network_tx_qp_out      <= tbl_qp[head_cid];
                    network_tx_ch_out      <= gnt;
                    network_tx_payload_out <= head[RPC_W-1:0];
                end
            end
        end
    end

    // ---------------- RX delivery ----------------
    logic rx_ok, rx_drop;

    assign rx_ok   = network_rx_valid_in && (int'(network_rx_ch_in) < N_CH)
                     && tbl_open[network_rx_conn_id_in];
    assign rx_drop = network_rx_valid_in && !rx_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            rpc_valid_out   <= '0;
            rpc_conn_id_out <= '0;
            rpc_data_out    <= '0;
        end else begin
            rpc_valid_out <= rx_ok ? (N_CH'(1) << network_rx_ch_in) : '0;
            if (rx_ok) begin
                rpc_conn_id_out <= network_rx_conn_id_in;
                rpc_data_out    <= network_rx_payload_in;
            end
        end
    end

    // ---------------- saturating drop counter ----------------
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, drop_cnt_out} + 17'(tx_drop) + 17'(rx_drop);

    always_ff @(posedge clk) begin
        if (reset) drop_cnt_out <= '0;
        else       drop_cnt_out <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
endmodule

// File: tb/tb_rpc_mc_engine.sv
// Directed bench for rpc_mc_engine with TX/RX scoreboards checked every cycle.

module tb_rpc_mc_engine;
    localparam int N_CH  = 4;
    localparam int CID_W = 4;
    localparam int RPC_W = 256;
    localparam int CW    = 2;

    typedef struct packed {
        logic [47:0]      addr;
        logic [63:0]      qp;
        logic [CW-1:0]    ch;
        logic [RPC_W-1:0] pl;
    } txf_t;

    typedef struct packed {
        logic [N_CH-1:0]  vec;
        logic [CID_W-1:0] cid;
        logic [RPC_W-1:0] pl;
    } rxf_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  conn_setup_en_in;
    logic [2:0]            conn_setup_cmd_in;
    logic [63:0]           conn_setup_data_in;
    logic                  conn_setup_done_out;
    logic [N_CH-1:0]       rpc_valid_in;
    logic [N_CH-1:0]       rpc_ready_out;
    logic [N_CH*CID_W-1:0] rpc_conn_id_in;
    logic [N_CH*RPC_W-1:0] rpc_data_in;
    logic                  network_tx_valid_out;
    logic                  network_tx_ready_in;
    logic [47:0]           network_tx_addr_out;
    logic [63:0]           network_tx_qp_out;
    logic [CW-1:0]         network_tx_ch_out;
    logic [RPC_W-1:0]      network_tx_payload_out;
    logic                  network_rx_valid_in;
    logic [CW-1:0]         network_rx_ch_in;
    logic [CID_W-1:0]      network_rx_conn_id_in;
    logic [RPC_W-1:0]      network_rx_payload_in;
    logic [N_CH-1:0]       rpc_valid_out;
    logic [CID_W-1:0]      rpc_conn_id_out;
    logic [RPC_W-1:0]      rpc_data_out;
    logic [15:0]           drop_cnt_out;
    logic                  error;

    rpc_mc_engine #(.NIC_ID(0), .N_CH(N_CH), .FIFO_DEPTH(8), .RPC_W(RPC_W), .CID_W(CID_W)) dut (
        .clk(clk), .reset(reset),
        .conn_setup_en_in(conn_setup_en_in), .conn_setup_cmd_in(conn_setup_cmd_in),
        .conn_setup_data_in(conn_setup_data_in), .conn_setup_done_out(conn_setup_done_out),
        .rpc_valid_in(rpc_valid_in), .rpc_ready_out(rpc_ready_out),
        .rpc_conn_id_in(rpc_conn_id_in), .rpc_data_in(rpc_data_in),
        .network_tx_valid_out(network_tx_valid_out), .network_tx_ready_in(network_tx_ready_in),
        .network_tx_addr_out(network_tx_addr_out), .network_tx_qp_out(network_tx_qp_out),
        .network_tx_ch_out(network_tx_ch_out), .network_tx_payload_out(network_tx_payload_out),
        .network_rx_valid_in(network_rx_valid_in), .network_rx_ch_in(network_rx_ch_in),
        .network_rx_conn_id_in(network_rx_conn_id_in), .network_rx_payload_in(network_rx_payload_in),
        .rpc_valid_out(rpc_valid_out), .rpc_conn_id_out(rpc_conn_id_out),
        .rpc_data_out(rpc_data_out), .drop_cnt_out(drop_cnt_out), .error(error)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   exp_drop = 0;
    txf_t txq[$];
    rxf_t rxq[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard compare of whatever the DUT presents this cycle.
    task automatic monitor();
        txf_t te;
        rxf_t re;
        if (network_tx_valid_out && network_tx_ready_in) begin
            te = '1;
            if (txq.size() > 0) te = txq.pop_front();
            chk("tx_frame", {network_tx_addr_out, network_tx_qp_out, network_tx_ch_out,
                             network_tx_payload_out}, te);
        end
        if (rpc_valid_out != '0) begin
            re = '1;
            if (rxq.size() > 0) re = rxq.pop_front();
            chk("rx_frame", {rpc_valid_out, rpc_conn_id_out, rpc_data_out}, re);
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [2:0] cmd, input logic [63:0] data);
        conn_setup_en_in   = 1'b1;
        conn_setup_cmd_in  = cmd;
        conn_setup_data_in = data;
        step();
        conn_setup_en_in   = 1'b0;
    endtask

    task automatic open_conn(input int cid, input logic [31:0] ip, input logic [15:0] port,
                             input logic [63:0] qp);
        setup(3'd0, 64'(cid));
        setup(3'd1, 64'd1);
        setup(3'd2, 64'(ip));
        setup(3'd3, 64'(port));
        setup(3'd4, qp);
        setup(3'd5, 64'd0);
        chk($sformatf("setup_done_c%0d", cid), conn_setup_done_out, 1'b1);
    endtask

    task automatic drive_tx(input int c, input int cid, input logic [RPC_W-1:0] pl);
        rpc_valid_in[c]                  = 1'b1;
        rpc_conn_id_in[c*CID_W +: CID_W] = CID_W'(cid);
        rpc_data_in[c*RPC_W +: RPC_W]    = pl;
    endtask

    task automatic drive_rx(input int c, input int cid, input logic [RPC_W-1:0] pl);
        network_rx_valid_in   = 1'b1;
        network_rx_ch_in      = CW'(c);
        network_rx_conn_id_in = CID_W'(cid);
        network_rx_payload_in = pl;
    endtask

    task automatic drain(input string tag, input int exp_cycles);
        int cyc = 0;
        while (txq.size() > 0 && cyc < 50) begin
            step();
            cyc++;
        end
        chk({tag, "_left"}, 512'(txq.size()), 512'(0));
        chk({tag, "_cycles"}, 512'(cyc), 512'(exp_cycles));
    endtask

    function automatic logic [RPC_W-1:0] mkpl(input int c, input int b);
        logic [RPC_W-1:0] v;
        v            = '0;
        v[31:0]      = 32'hA000_0000 | 32'(c << 8) | 32'(b);
        v[255:224]   = ~v[31:0];
        return v;
    endfunction

    function automatic txf_t mkf3(input int c, input logic [RPC_W-1:0] pl);
        txf_t f;
        f.addr = 48'h0A00_0001_1234;
        f.qp   = 64'h0011_0022_0000_0033;
        f.ch   = CW'(c);
        f.pl   = pl;
        return f;
    endfunction

    initial begin
        reset = 1'b1;
        conn_setup_en_in = 1'b0; conn_setup_cmd_in = '0; conn_setup_data_in = '0;
        rpc_valid_in = '0; rpc_conn_id_in = '0; rpc_data_in = '0;
        network_tx_ready_in = 1'b0;
        network_rx_valid_in = 1'b0; network_rx_ch_in = '0;
        network_rx_conn_id_in = '0; network_rx_payload_in = '0;
        #1;
        repeat (3) step();

        // Reset state
        chk("rst_ready", rpc_ready_out, '0);
        chk("rst_txv", network_tx_valid_out, 1'b0);
        chk("rst_drop", drop_cnt_out, 16'h0);
        chk("rst_err", error, 1'b0);
        chk("rst_done", conn_setup_done_out, 1'b0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", rpc_ready_out, 4'hF);

        open_conn(3, 32'h0A00_0001, 16'h1234, 64'h0011_0022_0000_0033);
        chk("err_after_open", error, 1'b0);

        // Round robin across all channels, two requests each
        network_tx_ready_in = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < N_CH; c++) begin
                drive_tx(c, 3, mkpl(c, b));
                txq.push_back(mkf3(c, mkpl(c, b)));
            end
            step();
        end
        rpc_valid_in = '0;
        step();
        chk("rr_head_held", {network_tx_addr_out, network_tx_qp_out, network_tx_ch_out,
                             network_tx_payload_out}, txq[0]);
        network_tx_ready_in = 1'b1;
        drain("rr", 8);

        // TX latency on idle block
        drive_tx(1, 3, mkpl(1, 7));
        txq.push_back(mkf3(1, mkpl(1, 7)));
        step();
        rpc_valid_in = '0;
        chk("lat_k1", network_tx_valid_out, 1'b0);
        step();
        chk("lat_k2", network_tx_valid_out, 1'b1);
        step();
        chk("lat_consumed", 512'(txq.size()), 512'(0));

        // Incomplete enable, then the retained fields complete it
        setup(3'd0, 64'd5);
        setup(3'd1, 64'd1);
        setup(3'd5, 64'd0);
        chk("inc_err", error, 1'b1);
        chk("inc_done", conn_setup_done_out, 1'b0);
        drive_tx(0, 5, mkpl(0, 9));
        step();
        rpc_valid_in = '0;
        step();
        step();
        exp_drop++;
        chk("inc_drop", drop_cnt_out, 16'(exp_drop));
        setup(3'd2, 64'h0A00_0002);
        setup(3'd3, 64'h0055);
        setup(3'd4, 64'h1);
        setup(3'd5, 64'd0);
        chk("retained_done", conn_setup_done_out, 1'b1);
        setup(3'd6, 64'd0);
        chk("bad_cmd_err", error, 1'b1);

        // Backpressure: ch2 fills while the sink stalls
        network_tx_ready_in = 1'b0;
        for (int b = 0; b < 9; b++) begin
            chk($sformatf("bp_ready_b%0d", b), rpc_ready_out[2], 1'b1);
            drive_tx(2, 3, mkpl(2, 16 + b));
            txq.push_back(mkf3(2, mkpl(2, 16 + b)));
            step();
        end
        rpc_valid_in = '0;
        chk("bp_full", rpc_ready_out[2], 1'b0);
        for (int i = 0; i < 11; i++) begin
            if (i % 3 == 0)
                chk("bp_stable", {network_tx_valid_out, network_tx_addr_out, network_tx_qp_out,
                                  network_tx_ch_out, network_tx_payload_out}, {1'b1, txq[0]});
            step();
        end
        network_tx_ready_in = 1'b1;
        drain("bp", 9);
        chk("bp_ready_back", rpc_ready_out[2], 1'b1);

        // RX delivery and drops
        drive_rx(1, 3, mkpl(9, 1));
        rxq.push_back('{vec: 4'b0010, cid: 4'd3, pl: mkpl(9, 1)});
        step();
        drive_rx(3, 3, mkpl(9, 2));
        rxq.push_back('{vec: 4'b1000, cid: 4'd3, pl: mkpl(9, 2)});
        step();
        drive_rx(0, 7, mkpl(9, 3));
        step();
        network_rx_valid_in = 1'b0;
        exp_drop++;
        step();
        chk("rx_closed_novalid", rpc_valid_out, 4'h0);
        chk("rx_drop", drop_cnt_out, 16'(exp_drop));
        chk("rx_q_empty", 512'(rxq.size()), 512'(0));

        // TX drop and RX drop land on the same edge
        drive_tx(0, 7, mkpl(0, 30));
        step();
        rpc_valid_in = '0;
        drive_rx(0, 7, mkpl(9, 4));
        chk("dual_before", drop_cnt_out, 16'(exp_drop));
        step();
        network_rx_valid_in = 1'b0;
        exp_drop += 2;
        chk("dual_after", drop_cnt_out, 16'(exp_drop));

        // Lookup coincident with a table write sees the old (closed) entry
        setup(3'd0, 64'd9);
        setup(3'd1, 64'd1);
        setup(3'd2, 64'h0A00_0009);
        setup(3'd3, 64'h0099);
        setup(3'd4, 64'h9);
        conn_setup_en_in = 1'b1; conn_setup_cmd_in = 3'd5;
        drive_rx(2, 9, mkpl(9, 5));
        step();
        conn_setup_en_in = 1'b0;
        exp_drop++;
        chk("wr_rd_done", conn_setup_done_out, 1'b1);
        chk("wr_rd_old", rpc_valid_out, 4'h0);
        rxq.push_back('{vec: 4'b0100, cid: 4'd9, pl: mkpl(9, 6)});
        drive_rx(2, 9, mkpl(9, 6));
        step();
        network_rx_valid_in = 1'b0;
        step();
        chk("wr_rd_new", 512'(rxq.size()), 512'(0));
        chk("wr_rd_drop", drop_cnt_out, 16'(exp_drop));

        // Reset while a frame is stalled
        network_tx_ready_in = 1'b0;
        drive_tx(1, 3, mkpl(1, 40));
        txq.push_back(mkf3(1, mkpl(1, 40)));
        step();
        rpc_valid_in = '0;
        step();
        chk("stall_valid", network_tx_valid_out, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", rpc_ready_out, 4'h0);
        step();
        chk("rst_mid_txv", network_tx_valid_out, 1'b0);
        chk("rst_mid_drop", drop_cnt_out, 16'h0);
        txq.delete();
        reset = 1'b0;
        #1;
        chk("rst_rel_ready", rpc_ready_out, 4'hF);
        chk("rst_rel_err", error, 1'b0);
        network_tx_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no_stale_tx", network_tx_valid_out, 1'b0);
        end

        // Saturation: stream dual drops (table closed after reset) up to 0xFFFE
        for (int i = 0; i < 32767; i++) begin
            drive_tx(0, 0, mkpl(0, 50));
            drive_rx(0, 0, mkpl(9, 50));
            step();
        end
        rpc_valid_in = '0;
        network_rx_valid_in = 1'b0;
        repeat (4) step();
        chk("sat_fffe", drop_cnt_out, 16'hFFFE);
        for (int r = 0; r < 2; r++) begin
            drive_tx(0, 0, mkpl(0, 51));
            step();
            rpc_valid_in = '0;
            drive_rx(0, 0, mkpl(9, 51));
            step();
            network_rx_valid_in = 1'b0;
            chk($sformatf("sat_ffff_%0d", r), drop_cnt_out, 16'hFFFF);
        end
        chk("end_tx_q", 512'(txq.size()), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
